// File: rtl/sprite_compositor.sv
// sprite_compositor: double-buffered solid-colour sprites over the video stream, 3-cycle pipeline with per-frame collision report
module sprite_compositor #(
    parameter int          NUM_SPRITES  = 4,
    parameter int          COORD_W      = 13,
    parameter int          SPRITE_W     = 16,
    parameter int          SPRITE_H     = 16,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter logic        VSYNC_ACTIVE = 1'b0,
    parameter int          IDX_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [2:0]             hve,
    input  logic [COORD_W-1:0]     x,
    input  logic [COORD_W-1:0]     y,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [COORD_W-1:0]     wr_x,
    input  logic [COORD_W-1:0]     wr_y,
    input  logic [23:0]            wr_color,
    input  logic                   wr_visible,
    output logic [7:0]             r,
    output logic [7:0]             g,
    output logic [7:0]             b,
    output logic [2:0]             hve_out,
    output logic                   commit,
    output logic                   collision,
    output logic [NUM_SPRITES-1:0] collision_mask
);
    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] SW = CW1'(SPRITE_W);
    localparam logic [CW1-1:0] SH = CW1'(SPRITE_H);

    logic [COORD_W-1:0]     sh_x [NUM_SPRITES];
    logic [COORD_W-1:0]     sh_y [NUM_SPRITES];
    logic [23:0]            sh_c [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_v;
    logic [COORD_W-1:0]     lv_x [NUM_SPRITES];
    logic [COORD_W-1:0]     lv_y [NUM_SPRITES];
    logic [23:0]            lv_c [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] lv_v;

    logic [2:0]             hve1, hve2;
    logic [COORD_W-1:0]     x1, y1;
    logic                   vs_q, vs_qq;
    logic                   commit_evt;
    logic [NUM_SPRITES-1:0] hit, hit2, acc_mask;
    logic                   acc_flag, multi;
    logic [23:0]            pix;

    assign commit_evt = (vs_q == VSYNC_ACTIVE) && (vs_qq != VSYNC_ACTIVE);
    assign multi      = |(hit2 & (hit2 - NUM_SPRITES'(1)));

    // Live copy samples the shadow before any same-edge write lands
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
                sh_c[i] <= '0;
                lv_x[i] <= '0;
                lv_y[i] <= '0;
                lv_c[i] <= '0;
            end
            sh_v <= '0;
            lv_v <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    sh_x[i] <= wr_x;
                    sh_y[i] <= wr_y;
                    sh_c[i] <= wr_color;
                    sh_v[i] <= wr_visible;
                end
                if (commit_evt) begin
                    lv_x[i] <= sh_x[i];
                    lv_y[i] <= sh_y[i];
                    lv_c[i] <= sh_c[i];
                    lv_v[i] <= sh_v[i];
                end
            end
        end
    end

    // Widened compare so a sprite near the coordinate limit clips instead of wrapping
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++)
            hit[i] = hve1[0] && lv_v[i] &&
                     ({1'b0, x1} >= {1'b0, lv_x[i]}) && ({1'b0, x1} < {1'b0, lv_x[i]} + SW) &&
                     ({1'b0, y1} >= {1'b0, lv_y[i]}) && ({1'b0, y1} < {1'b0, lv_y[i]} + SH);
    end

    always_comb begin
        pix = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if (hit2[i]) pix = lv_c[i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hve1           <= '0;
            x1             <= '0;
            y1             <= '0;
            vs_q           <= ~VSYNC_ACTIVE;
            vs_qq          <= ~VSYNC_ACTIVE;
            hve2           <= '0;
            hit2           <= '0;
            hve_out        <= '0;
            {r, g, b}      <= '0;
            commit         <= 1'b0;
            collision      <= 1'b0;
            collision_mask <= '0;
            acc_flag       <= 1'b0;
            acc_mask       <= '0;
        end else begin
            hve1      <= hve;
            x1        <= x;
            y1        <= y;
            vs_q      <= hve[1];
            vs_qq     <= vs_q;
            hve2      <= hve1;
            hit2      <= hit;
            hve_out   <= hve2;
            {r, g, b} <= hve2[0] ? pix : 24'h0;
            commit    <= commit_evt;
            if (commit_evt) begin
                collision      <= acc_flag;
                collision_mask <= acc_mask;
                acc_flag       <= 1'b0;
                acc_mask       <= '0;
            end else if (multi) begin
                acc_flag <= 1'b1;
                acc_mask <= acc_mask | hit2;
            end
        end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: randomized scoreboard bench with a frame-level behavioural model of the compositor
module tb_sprite_compositor;
    localparam int          NS  = 4;
    localparam int          SW  = 16;
    localparam int          SH  = 16;
    localparam int          MAXC = 8191;
    localparam logic [23:0] BG  = 24'h203040;
    localparam logic        VA  = 1'b0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  hve = '0;
    logic [12:0] x = '0, y = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [12:0] wr_x = '0, wr_y = '0;
    logic [23:0] wr_color = '0;
    logic        wr_visible = 1'b0;
    logic [7:0]  r, g, b;
    logic [2:0]  hve_out;
    logic        commit, collision;
    logic [3:0]  collision_mask;

    sprite_compositor #(
        .NUM_SPRITES(NS), .COORD_W(13), .SPRITE_W(SW), .SPRITE_H(SH),
        .BG_COLOR(BG), .VSYNC_ACTIVE(VA), .IDX_W(3)
    ) dut (
        .clock(clock), .reset_n(reset_n), .hve(hve), .x(x), .y(y),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .wr_visible(wr_visible),
        .r(r), .g(g), .b(b), .hve_out(hve_out), .commit(commit),
        .collision(collision), .collision_mask(collision_mask)
    );

    always #5 clock = ~clock;

    typedef struct { logic [2:0] hve; logic [23:0] rgb; } pix_t;
    typedef struct { logic commit; logic coll; logic [3:0] mask; } ctl_t;
    pix_t pix_q[$];
    ctl_t ctl_q[$];

    int n_vec = 0, n_err = 0;

    int          sh_x[NS], sh_y[NS], lv_x[NS], lv_y[NS];
    logic [23:0] sh_c[NS], lv_c[NS];
    bit          sh_v[NS], lv_v[NS];
    logic        m_prev_vs = ~VA;
    logic [3:0]  m_acc_mask = '0, m_mask = '0;
    logic        m_acc_flag = 1'b0, m_coll = 1'b0;

    bit          p_we = 0;
    logic [2:0]  p_idx = '0;
    logic [12:0] p_x = '0, p_y = '0;
    logic [23:0] p_c = '0;
    bit          p_v = 0;

    function automatic int clampc(input int v);
        return v < 0 ? 0 : (v > MAXC ? MAXC : v);
    endfunction

    // One pixel per clock: drive it, then advance the reference model by one pixel
    task automatic step(input logic [2:0] h, input int px, input int py);
        logic [3:0]  hits;
        logic [23:0] rgb;
        bit          edge_seen;
        @(negedge clock);
        hve = h; x = 13'(px); y = 13'(py);
        wr_en = p_we; wr_idx = p_idx; wr_x = p_x; wr_y = p_y; wr_color = p_c; wr_visible = p_v;
        p_we = 0;
        hits = '0;
        for (int i = 0; i < NS; i++)
            hits[i] = h[0] && lv_v[i] && px >= lv_x[i] && px < lv_x[i] + SW && py >= lv_y[i] && py < lv_y[i] + SH;
        rgb = BG;
        for (int i = NS - 1; i >= 0; i--) if (hits[i]) rgb = lv_c[i];
        if (!h[0]) rgb = '0;
        if ($countones(hits) >= 2) begin
            m_acc_mask |= hits;
            m_acc_flag = 1'b1;
        end
        if (wr_en && int'(wr_idx) < NS) begin
            sh_x[wr_idx] = int'(wr_x); sh_y[wr_idx] = int'(wr_y);
            sh_c[wr_idx] = wr_color;   sh_v[wr_idx] = wr_visible;
        end
        edge_seen = (h[1] == VA) && (m_prev_vs != VA);
        m_prev_vs = h[1];
        if (edge_seen) begin
            lv_x = sh_x; lv_y = sh_y; lv_c = sh_c; lv_v = sh_v;
            m_coll = m_acc_flag; m_mask = m_acc_mask;
            m_acc_flag = 1'b0; m_acc_mask = '0;
        end
        pix_q.push_back('{h, rgb});
        ctl_q.push_back('{edge_seen, m_coll, m_mask});
    endtask

    task automatic blank();
        step({1'($urandom), ~VA, 1'b0}, int'($urandom_range(0, MAXC)), int'($urandom_range(0, MAXC)));
    endtask

    task automatic vs_step();
        step({1'($urandom), VA, 1'b0}, int'($urandom_range(0, MAXC)), int'($urandom_range(0, MAXC)));
    endtask

    task automatic wr(input int idx, input int sx, input int sy, input logic [23:0] c, input bit v);
        p_we = 1; p_idx = 3'(idx); p_x = 13'(sx); p_y = 13'(sy); p_c = c; p_v = v;
        blank();
    endtask

    // late=1 holds the pending write back until the cycle in which the commit is detected
    task automatic vblank(input bit late);
        bit sv;
        sv = p_we;
        if (late) p_we = 0;
        repeat (3) blank();
        vs_step();
        if (late) p_we = sv;
        repeat (3) vs_step();
        repeat (3) blank();
    endtask

    task automatic rand_pix(input int n, input int cx, input int cy, input int span);
        for (int k = 0; k < n; k++)
            step({1'($urandom), ~VA, 1'($urandom_range(0, 7) != 0)},
                 clampc(cx - span + int'($urandom_range(0, 2 * span))),
                 clampc(cy - span + int'($urandom_range(0, 2 * span))));
    endtask

    task automatic grid(input int x0, input int y0);
        int dx[5] = '{-1, 0, 7, 15, 16};
        int dy[5] = '{-1, 0, 7, 15, 16};
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                step({1'b1, ~VA, 1'b1}, clampc(x0 + dx[i]), clampc(y0 + dy[j]));
    endtask

    always @(posedge clock) begin
        pix_t pe;
        ctl_t ce;
        #1;
        if (pix_q.size() >= 3) begin
            pe = pix_q.pop_front();
            n_vec++;
            if (hve_out !== pe.hve || {r, g, b} !== pe.rgb) begin
                n_err++;
                $display("FAIL pixel: hve_out=%b rgb=%h, expected hve_out=%b rgb=%h", hve_out, {r, g, b}, pe.hve, pe.rgb);
            end
        end
        if (ctl_q.size() >= 2) begin
            ce = ctl_q.pop_front();
            n_vec++;
            if (commit !== ce.commit || collision !== ce.coll || collision_mask !== ce.mask) begin
                n_err++;
                $display("FAIL control: commit=%b collision=%b mask=%b, expected commit=%b collision=%b mask=%b",
                         commit, collision, collision_mask, ce.commit, ce.coll, ce.mask);
            end
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_c[i] = '0; sh_v[i] = 0;
            lv_x[i] = 0; lv_y[i] = 0; lv_c[i] = '0; lv_v[i] = 0;
        end
        repeat (6) begin
            @(negedge clock);
            hve = 3'($urandom); x = 13'($urandom); y = 13'($urandom);
            wr_en = 1'($urandom); wr_idx = 3'($urandom); wr_x = 13'($urandom); wr_y = 13'($urandom);
            wr_color = 24'($urandom); wr_visible = 1'($urandom);
            #2;
            n_vec++;
            if ({r, g, b, hve_out, commit, collision, collision_mask} !== '0) begin
                n_err++;
                $display("FAIL reset: rgb=%h hve_out=%b commit=%b collision=%b mask=%b, expected all zero",
                         {r, g, b}, hve_out, commit, collision, collision_mask);
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        rand_pix(40, 512, 384, 500);
        wr(0, 100, 50, 24'hFF0000, 1);
        rand_pix(40, 108, 58, 20);
        vblank(0);
        grid(100, 50);
        rand_pix(80, 108, 58, 20);
        wr(0, 300, 50, 24'hFF0000, 1);
        grid(100, 50);
        grid(300, 50);
        vblank(0);
        grid(300, 50);
        grid(100, 50);
        wr(0, 100, 50, 24'hFF0000, 1);
        wr(1, 108, 50, 24'h00FF00, 1);
        vblank(0);
        grid(100, 50);
        grid(108, 50);
        rand_pix(120, 112, 58, 20);
        p_we = 1; p_idx = 3'd1; p_x = 13'd600; p_y = 13'd50; p_c = 24'h00FF00; p_v = 1;
        vblank(1);
        grid(108, 50);
        rand_pix(60, 112, 58, 20);
        vblank(0);
        grid(600, 50);
        rand_pix(60, 112, 58, 20);
        vblank(0);
        wr(2, 8190, 300, 24'h0000FF, 1);
        wr(3, 400, 8190, 24'hFFFF00, 1);
        wr(5, 100, 50, 24'hFFFFFF, 1);
        wr(4, 0, 0, 24'hFFFFFF, 1);
        wr(1, 104, 54, 24'h00FF00, 0);
        vblank(0);
        for (int i = 0; i < 14; i++) step({1'b1, ~VA, 1'b1}, i, 305);
        for (int i = 0; i < 14; i++) step({1'b1, ~VA, 1'b1}, 405, i);
        grid(8190, 300);
        grid(400, 8190);
        grid(100, 50);
        rand_pix(60, 108, 58, 20);
        vblank(0);
        rand_pix(20, 108, 58, 20);
        vblank(0);
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NS; i++)
                wr(i, 180 + int'($urandom_range(0, 40)), 180 + int'($urandom_range(0, 40)),
                   24'($urandom), $urandom_range(0, 3) != 0);
            vblank(f[0]);
            rand_pix(250, 208, 208, 45);
        end
        vblank(0);
        repeat (4) blank();
        @(posedge clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised multi-sprite compositor between the video timing generator and the HDMI encoder, on the pixel clock. Successor to the single-sprite pattern path. Holds N rectangular solid-colour sprites, each with a CPU-side shadow copy and a live copy. Shadow copies commit to live at frame boundaries so there is no mid-frame tearing. Outputs per-pixel RGB through a fixed 3-cycle pipeline, with delayed sync so that sync stays aligned. Also reports per-frame sprite collisions.

## Interface
Parameters:
- NUM_SPRITES, 4: sprite count, 1..16; IDX_W = max(1, clog2(NUM_SPRITES)).
- COORD_W, 13: width of x, y and sprite coordinates.
- SPRITE_W, 16: sprite width in pixels, 1..2^COORD_W-1.
- SPRITE_H, 16: sprite height in pixels, same range.
- BG_COLOR, 24'h000000: background {r,g,b}.
- VSYNC_ACTIVE, 1'b0: level of hve[1] during vsync.

Ports:
- clock  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- hve  in  3  {hsync, vsync, data_enable} from the timing generator.
- x  in  COORD_W  current pixel column.
- y  in  COORD_W  current pixel row.
- wr_en  in  1  write strobe to a shadow sprite entry.
- wr_idx  in  IDX_W  sprite index; writes with index ≥ NUM_SPRITES are ignored.
- wr_x  in  COORD_W  sprite left edge.
- wr_y  in  COORD_W  sprite top edge.
- wr_color  in  24  sprite colour {r,g,b}.
- wr_visible  in  1  sprite enable.
- r, g, b  out  8 each  pixel colour.
- hve_out  out  3  hve delayed 3 cycles.
- commit  out  1  one-cycle pulse when shadow is copied to live.
- collision  out  1  at least one sprite pair overlapped on a displayed pixel in the previous frame.
- collision_mask  out  NUM_SPRITES  sprites involved in any overlap in the previous frame.

## Operation
- Each sprite has a shadow entry {x, y, color, visible} and a live entry with the same fields.
- wr_en=1 writes the shadow entry at wr_idx on that clock edge. The write port is always ready and never stalls.
- Commit event: hve[1] changes from the inactive level to VSYNC_ACTIVE (edge detected on the registered hve[1]). On a commit event:
  - all shadow entries are copied to live;
  - commit pulses;
  - collision and collision_mask load from the running accumulators;
  - the accumulators clear.
- A write in the same cycle as a commit event updates the shadow only. The live copy takes the pre-write shadow value, so the write becomes visible one frame later.
- Hit test for sprite i, in COORD_W+1-bit unsigned arithmetic: x ≥ sx_i and x < sx_i+SPRITE_W and y ≥ sy_i and y < sy_i+SPRITE_H and visible_i and data_enable. Sprites do not wrap: a sprite near the maximum coordinate is clipped, never shown at 0.
- Priority: the lowest-index hit sprite supplies the colour. If no sprite hits, the colour is BG_COLOR.
- Outside data_enable, rgb = 0.
- Collision: if two or more hit bits are set for a pixel, OR those hit bits into the mask accumulator and set the flag accumulator.

## Timing
- Stage 1: register hve, x, y. Stage 2: register the hit vector. Stage 3: priority mux and register r/g/b/hve_out.
- Latency is exactly 3 clocks from hve/x/y to rgb/hve_out. Throughput is one pixel per clock.
- The commit edge is detected in stage 1. Live registers update on the following edge, so a write takes effect on pixels presented at least 2 cycles after the commit pulse. The vsync period guarantees these are non-displayed pixels.
- commit is high for exactly 1 cycle per vsync assertion.
- Reset (asynchronous assert, release on clock):
  - shadow and live: x=0, y=0, color=0, visible=0;
  - pipeline registers 0;
  - r=g=b=0, hve_out=3'b000, commit=0, collision=0, collision_mask=0, accumulators 0;
  - the hve[1] history register resets to the inactive level.
- Reset mid-frame discards everything. Output returns to background with correct sync 3 cycles after reset release.

## Test plan
- Reset: hold reset_n=0 with random inputs → all outputs 0; release and drive 1024×768 timing → rgb=BG_COLOR in the active area, hve_out equals hve delayed by 3.
- Single sprite: write idx0 x=100 y=50 color=24'hFF0000 visible=1, then wait one vsync → at y=50..65, x=100..115 output FF0000 three cycles later; x=99 and x=116 give background.
- Double buffering: rewrite idx0 to x=300 mid-frame → the current frame still shows x=100; the next frame shows x=300; a write in the exact commit cycle appears one frame late.
- Priority and collision: idx1 at x=108 color 00FF00, overlapping idx0 → overlap pixels show FF0000; after the next commit, collision=1 and collision_mask=4'b0011; a frame without overlap → collision clears at the following commit.
- Clipping: sprite at x=8190 with COORD_W=13 → no hit at x=0..13; y=8190 has the same behaviour vertically.
- Out-of-range and invisible: wr_idx=5 with NUM_SPRITES=4 has no effect; visible=0 → background and no collision contribution.
